// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants and state encoding for the interrupt controller
package int_ctrl_pkg;
  localparam int NUM_SRC_DEF = 8;
  localparam int ID_W_DEF = 3;
  localparam logic [3:0] OFF_CTRL = 4'h0;
  localparam logic [3:0] OFF_ENABLE = 4'h4;
  localparam logic [3:0] OFF_PENDING = 4'h8;
  localparam logic [3:0] OFF_ID = 4'hC;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ = 2'd1,
    SERVICE = 2'd2
  } state_e;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational priority encoder, lowest set index wins
module int_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] id_o,
  output logic         valid_o
);
  // scan from the top so the lowest set index is the last assignment
  always_comb begin
    id_o = '0;
    for (int i = N - 1; i >= 0; i--) id_o = req_i[i] ? W'(i) : id_o;
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: edge-captured, masked, prioritised interrupt aggregator with req/ack/done handshake
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        data_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  output logic [31:0]        data_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               int_req_o,
  output logic [ID_W-1:0]    int_id_o,
  input  logic               int_ack_i,
  input  logic               int_done_i
);
  logic ctrl_q, ctrl_d;
  logic [NUM_SRC-1:0] enable_q, enable_d, pending_q, pending_d, src_dly_q, src_dly_d;
  logic [NUM_SRC-1:0] cand, cand_nxt, ack_mask, w1c;
  logic [ID_W-1:0] id_q, id_d, win_id;
  logic win_v;
  state_e state_q, state_d;
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], data_i[31:NUM_SRC]};
  // arbitration runs on registered pending so a captured edge requests one cycle later
  assign cand = ctrl_q ? pending_q & enable_q : '0;
  int_prio_enc #(.N(NUM_SRC), .W(ID_W)) u_enc (
    .req_i  (cand),
    .id_o   (win_id),
    .valid_o(win_v)
  );
  // register writes and edge capture; a new edge beats any clear on the same bit
  always_comb begin
    w1c = (we_i && addr_i[3:0] == OFF_PENDING) ? data_i[NUM_SRC-1:0] : '0;
    ack_mask = (state_q == REQ && int_ack_i) ? NUM_SRC'(1) << id_q : '0;
    ctrl_d = (we_i && addr_i[3:0] == OFF_CTRL) ? data_i[0] : ctrl_q;
    enable_d = (we_i && addr_i[3:0] == OFF_ENABLE) ? data_i[NUM_SRC-1:0] : enable_q;
    src_dly_d = src_i;
    pending_d = (pending_q & ~(w1c | ack_mask)) | (src_i & ~src_dly_q);
    cand_nxt = ctrl_d ? pending_d & enable_d : '0;
  end
  // handshake FSM; withdraw looks at next-cycle candidates so a clear drops the request at once
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    case (state_q)
      IDLE: begin
        state_d = win_v ? REQ : IDLE;
        id_d = win_v ? win_id : id_q;
      end
      REQ: state_d = int_ack_i ? SERVICE : (cand_nxt[id_q] ? REQ : IDLE);
      SERVICE: state_d = int_done_i ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  // state and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= 1'b0;
      enable_q <= '0;
      pending_q <= '0;
      src_dly_q <= '0;
      id_q <= '0;
      state_q <= IDLE;
    end else begin
      ctrl_q <= ctrl_d;
      enable_q <= enable_d;
      pending_q <= pending_d;
      src_dly_q <= src_dly_d;
      id_q <= id_d;
      state_q <= state_d;
    end
  end
  // combinational bus read, forced to zero while in reset
  always_comb begin
    data_o = rst ? ZERO_WORD :
             addr_i[3:0] == OFF_CTRL    ? {30'b0, state_q == SERVICE, ctrl_q} :
             addr_i[3:0] == OFF_ENABLE  ? 32'(enable_q) :
             addr_i[3:0] == OFF_PENDING ? 32'(pending_q) :
             addr_i[3:0] == OFF_ID      ? {state_q == REQ || state_q == SERVICE, 31'(id_q)} :
             ZERO_WORD;
  end
  assign int_req_o = state_q == REQ;
  assign int_id_o = id_q;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl, register reads and request events checked by a monitor
module tb_int_ctrl;
  logic clk = 0, rst = 1, we_i = 0, int_ack_i = 0, int_done_i = 0;
  logic [31:0] data_i = 0, addr_i = 0, data_o;
  logic [7:0] src_i = 0;
  logic int_req_o;
  logic [2:0] int_id_o;
  typedef struct {
    string name;
    bit kind;
    logic [31:0] exp;
  } chk_t;
  chk_t chk_q[$];
  int req_q[$];
  int checks = 0, failures = 0;
  logic chk_v = 0, req_prev = 0;

  int_ctrl dut (
    .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i), .data_o(data_o),
    .src_i(src_i), .int_req_o(int_req_o), .int_id_o(int_id_o),
    .int_ack_i(int_ack_i), .int_done_i(int_done_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    chk_t c;
    logic [31:0] act;
    int e;
    if (chk_v) begin
      checks++;
      if (chk_q.size() == 0) begin
        failures++;
        $display("FAIL chk_underflow: no expected value queued");
      end else begin
        c = chk_q.pop_front();
        act = c.kind ? {28'b0, int_req_o, int_id_o} : data_o;
        if (act !== c.exp) begin
          failures++;
          $display("FAIL %s: got=%h want=%h", c.name, act, c.exp);
        end
      end
    end
    if (int_req_o && !req_prev) begin
      checks++;
      if (req_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_req: id got=%0d want=none", int_id_o);
      end else begin
        e = req_q.pop_front();
        if (int_id_o !== 3'(e)) begin
          failures++;
          $display("FAIL req_id: got=%0d want=%0d", int_id_o, e);
        end
      end
    end
    req_prev = int_req_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we_i = 1; addr_i = {28'b0, a}; data_i = d;
    step();
    we_i = 0; data_i = 0;
  endtask

  task automatic chk(input string name, input bit kind, input logic [3:0] a, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp;
    addr_i = {28'b0, a};
    chk_q.push_back(c);
    chk_v = 1;
    step();
    chk_v = 0;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    src_i = v;
    step();
    src_i = 0;
  endtask

  task automatic ack();
    int_ack_i = 1; step(); int_ack_i = 0;
  endtask

  task automatic done();
    int_done_i = 1; step(); int_done_i = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_data_zero", 0, 4'h4, 32'h0);
    rst = 0;
    chk("rst_ctrl", 0, 4'h0, 32'h0);
    chk("rst_enable", 0, 4'h4, 32'h0);
    chk("rst_pending", 0, 4'h8, 32'h0);
    chk("rst_id", 0, 4'hC, 32'h0);
    chk("rst_req", 1, 4'h0, 32'h0);
    // single source service
    wr(4'h4, 32'h01);
    wr(4'h0, 32'h1);
    req_q.push_back(0);
    pulse_src(8'h01);
    chk("t1_pending", 0, 4'h8, 32'h01);
    chk("t1_req", 1, 4'h0, 32'h8);
    ack();
    chk("t1_pend_acked", 0, 4'h8, 32'h0);
    chk("t1_ctrl_busy", 0, 4'h0, 32'h3);
    done();
    chk("t1_ctrl_idle", 0, 4'h0, 32'h1);
    chk("t1_req_low", 1, 4'h0, 32'h0);
    chk("t1_bad_off", 0, 4'h2, 32'h0);
    // simultaneous edges: lowest index first, then back-to-back
    wr(4'h4, 32'hFF);
    chk("t2_enable", 0, 4'h4, 32'hFF);
    req_q.push_back(2);
    req_q.push_back(5);
    pulse_src(8'h24);
    chk("t2_pending", 0, 4'h8, 32'h24);
    ack();
    done();
    step();
    ack();
    chk("t2_pend_clear", 0, 4'h8, 32'h0);
    chk("t2_id_valid", 0, 4'hC, 32'h8000_0005);
    done();
    // W1C withdraws a pending request
    req_q.push_back(3);
    pulse_src(8'h08);
    step();
    chk("t3_id_req", 0, 4'hC, 32'h8000_0003);
    wr(4'h8, 32'h08);
    chk("t3_withdrawn", 1, 4'h0, 32'h3);
    chk("t3_id_invalid", 0, 4'hC, 32'h3);
    chk("t3_ctrl_idle", 0, 4'h0, 32'h1);
    // ack colliding with W1C: ack wins
    req_q.push_back(3);
    pulse_src(8'h08);
    step();
    int_ack_i = 1; we_i = 1; addr_i = 32'h8; data_i = 32'h08;
    step();
    int_ack_i = 0; we_i = 0; data_i = 0;
    chk("t3_ack_wins", 0, 4'h0, 32'h3);
    chk("t3_pend_zero", 0, 4'h8, 32'h0);
    done();
    // edge and W1C on the same bit: set wins
    req_q.push_back(1);
    src_i = 8'h02; we_i = 1; addr_i = 32'h8; data_i = 32'h02;
    step();
    src_i = 0; we_i = 0; data_i = 0;
    chk("t4_set_wins", 0, 4'h8, 32'h02);
    ack();
    done();
    // held level does not re-pend
    req_q.push_back(0);
    src_i = 8'h01;
    step(); step();
    ack();
    done();
    repeat (100) step();
    chk("t5_no_rereq", 1, 4'h0, 32'h0);
    chk("t5_no_pend", 0, 4'h8, 32'h0);
    src_i = 0;
    step();
    req_q.push_back(0);
    src_i = 8'h01;
    step(); step();
    chk("t5_rereq", 1, 4'h0, 32'h8);
    ack();
    done();
    src_i = 0;
    // reset during SERVICE with a pending source
    req_q.push_back(4);
    pulse_src(8'h10);
    step();
    ack();
    pulse_src(8'h10);
    chk("t6_pending", 0, 4'h8, 32'h10);
    chk("t6_busy", 0, 4'h0, 32'h3);
    rst = 1;
    chk("t6_rst_read", 0, 4'h8, 32'h0);
    rst = 0;
    chk("t6_ctrl", 0, 4'h0, 32'h0);
    chk("t6_enable", 0, 4'h4, 32'h0);
    chk("t6_pending0", 0, 4'h8, 32'h0);
    chk("t6_id", 0, 4'hC, 32'h0);
    chk("t6_req", 1, 4'h0, 32'h0);
    done();
    chk("t6_done_ign", 0, 4'h0, 32'h0);
    chk("t6_req_after", 1, 4'h0, 32'h0);
    repeat (3) step();
    checks++;
    if (req_q.size() != 0) begin
      failures++;
      $display("FAIL missing_req: outstanding got=%0d want=0", req_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt aggregation stage that sits directly downstream of the timer and the other peripheral interrupt lines.
- Captures source rising edges into pending bits and masks them with per-source enables.
- Selects the highest-priority request and presents one interrupt request plus ID to the core, using a request/ack/done handshake.
- Software-visible through the same peripheral bus slave interface as the timer: 32-bit data, address offset in addr_i[3:0], single-cycle writes, combinational reads.

Parameters:
- NUM_SRC, 8, number of interrupt source lines; index 0 is the timer.
- ID_W, 3, width of the source ID; equals clog2(NUM_SRC).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- data_i  input  32  bus write data
- addr_i  input  32  bus address; only [3:0] decoded
- we_i  input  1  bus write enable
- data_o  output  32  bus read data
- src_i  input  NUM_SRC  level interrupt lines from peripherals; timer int_sig_o on bit 0
- int_req_o  output  1  interrupt request to core
- int_id_o  output  ID_W  ID of the requested/serviced source
- int_ack_i  input  1  one-cycle pulse: core has taken the request
- int_done_i  input  1  one-cycle pulse: handler finished (mret)

Behaviour:
- Registers:
  - 0x0 CTRL: [0] global enable (RW); [1] busy = state SERVICE (RO).
  - 0x4 ENABLE: [NUM_SRC-1:0] RW.
  - 0x8 PENDING: read returns pending; write-1-to-clear.
  - 0xC ID: [ID_W-1:0] last latched ID; [31] valid = state REQ or SERVICE.
  - Other offsets read 0; writes to them are ignored. Unimplemented register bits read 0.
- Reset (synchronous, clk edge with rst=1):
  - CTRL, ENABLE, PENDING, src_d and latched ID clear to 0; state goes to IDLE.
  - int_req_o=0, int_id_o=0.
  - data_o=0 combinationally while rst=1.
  - A reset in REQ or SERVICE abandons the transaction silently; no done is required.
- Edge capture:
  - src_d registers src_i every cycle.
  - pending[i] sets when src_i[i] & ~src_d[i].
  - pending[i] clears on W1C, or on ack for the latched ID.
  - If set and clear hit the same bit in the same cycle, set wins.
- Arbitration: cand = pending & ENABLE when CTRL[0]=1, else cand = 0. The lowest set index wins; this is pure combinational priority.
- State machine (registered):
  - IDLE: if cand != 0, latch ID = winner and go to REQ (request visible the cycle after the edge is captured).
  - REQ: int_req_o=1, int_id_o = latched ID.
    - int_ack_i=1: clear pending[ID], go to SERVICE.
    - Else if cand[ID]=0 (cleared, disabled, or global-disabled): withdraw, go to IDLE.
    - A higher-priority arrival does not re-latch while in REQ.
  - SERVICE: int_req_o=0, int_id_o holds.
    - int_done_i=1: go to IDLE.
    - New edges accumulate in pending.
  - Ack and withdraw in the same cycle: ack wins.
  - int_ack_i outside REQ and int_done_i outside SERVICE are ignored.
- Timing:
  - Minimum latency from src_i rise to int_req_o = 2 clk (capture, then latch).
  - Back-to-back service: IDLE → REQ one cycle after done if cand != 0.
- A level source held high does not re-pend; it needs a fresh 0→1 edge.

Decomposition:
- Shared defines (existing core defines file): RstEnable, WriteEnable, ZeroWord, INT_ASSERT/INT_DEASSERT, register offsets, state encodings (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2).
- One natural sub-module: int_prio_enc (NUM_SRC-bit vector → ID_W index + valid, lowest index wins, combinational).

Test Plan:
- Reset, then ENABLE=0x01, CTRL=0x1; pulse src_i[0] → PENDING reads 0x01, int_req_o=1 with int_id_o=0 two clk later; ack → PENDING=0, CTRL reads 0x3; done → CTRL reads 0x1, int_req_o stays 0.
- ENABLE=0xFF, src_i rises 0x24 in one cycle → ID 2 requested first; ack, done → ID 5 requested next cycle; ack → PENDING=0.
- In REQ for ID 3, write PENDING=0x08 → int_req_o drops next cycle, state IDLE, ID[31]=0; ack in the same cycle as the W1C → ack wins, SERVICE entered.
- Set and W1C collide: edge on src_i[1] in the same cycle as a write of PENDING=0x02 → PENDING reads 0x02.
- src_i[0] held high 100 cycles after one service → no second request; drop and re-raise → new request.
- Assert rst in SERVICE with PENDING=0x10 → next cycle all registers read 0, int_req_o=0; done pulse after reset has no effect.
